tri_queue: RTL and testbench



---
 rtl/tri_queue.sv | 82 ++++++++
 tb/tb_tri_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tri_queue.sv
// rtl/tri_queue.sv - DEPTH-entry triangle FIFO feeding rast's R10 input
module tri_queue #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int DEPTH  = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] in_tri_S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          in_color_U,
    input  logic                                         in_valid_H,
    output logic                                         in_ready_H,
    input  logic                                         flush_H,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U,
    output logic                                         validTri_R10H,
    input  logic                                         halt_RnnnnL,
    output logic [$clog2(DEPTH+1)-1:0]                   count_U
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RADIX >= SIGFIG) begin : g_param_check
        $error("tri_queue: DEPTH must be a power of two >= 2 and RADIX < SIGFIG");
    end

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri_mem [DEPTH];
    logic [COLORS-1:0][SIGFIG-1:0]          r_col_mem [DEPTH];
    logic [PW-1:0]                          r_wp;
    logic [PW-1:0]                          r_rp;
    logic [CW-1:0]                          r_count;
    logic                                   w_push;
    logic                                   w_pop;

    // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign in_ready_H    = (r_count < CW'(DEPTH));
    assign validTri_R10H = (r_count != '0);
    assign count_U       = r_count;
    assign w_push        = in_valid_H & in_ready_H;
    assign w_pop         = validTri_R10H & halt_RnnnnL;
    assign tri_R10S      = r_tri_mem[r_rp];
    assign color_R10U    = r_col_mem[r_rp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tri_mem[i] <= '0;
                r_col_mem[i] <= '0;
            end
        end else if (w_push && !flush_H) begin
            r_tri_mem[r_wp] <= in_tri_S;
            r_col_mem[r_wp] <= in_color_U;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush_H) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_tri_queue.sv
// tb/tb_tri_queue.sv - directed self-checking bench for tri_queue
module tb_tri_queue;
    typedef logic signed [2:0][2:0][23:0] tri_t;
    typedef logic        [2:0][23:0]      col_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    tri_t       in_tri_S = '0;
    col_t       in_color_U = '0;
    logic       in_valid_H = 1'b0;
    logic       in_ready_H;
    logic       flush_H = 1'b0;
    tri_t       tri_R10S;
    col_t       color_R10U;
    logic       validTri_R10H;
    logic       halt_RnnnnL = 1'b0;
    logic [2:0] count_U;

    int checks = 0;
    int failures = 0;

    tri_queue #(.SIGFIG(24), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_tri_S(in_tri_S), .in_color_U(in_color_U), .in_valid_H(in_valid_H),
        .in_ready_H(in_ready_H), .flush_H(flush_H),
        .tri_R10S(tri_R10S), .color_R10U(color_R10U), .validTri_R10H(validTri_R10H),
        .halt_RnnnnL(halt_RnnnnL), .count_U(count_U)
    );

    always #5 clk = ~clk;

    function automatic tri_t tri_of(input int n);
        tri_t t;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                t[v][a] = 24'((n * 9 + v * 3 + a + 1) << 10);
        if (n == 0) t[0][2] = '0;
        t[2][1] = -t[2][1];
        return t;
    endfunction

    function automatic col_t col_of(input int n);
        col_t c;
        for (int k = 0; k < 3; k++) c[k] = 24'(n * 256 + k * 17 + 5);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int n);
        in_tri_S   = tri_of(n);
        in_color_U = col_of(n);
        in_valid_H = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        offer(0);
        halt_RnnnnL = 1'b1;
        step();
        step();
        checks++; if (validTri_R10H !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", validTri_R10H); end
        checks++; if (count_U !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count_U); end
        checks++; if (in_ready_H !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", in_ready_H); end
        checks++; if (tri_R10S !== '0) begin failures++; $display("FAIL reset_tri got=%h want=0", tri_R10S); end
        checks++; if (color_R10U !== '0) begin failures++; $display("FAIL reset_color got=%h want=0", color_R10U); end
        rst = 1'b1;
        halt_RnnnnL = 1'b0;
        step();
        in_valid_H = 1'b0;
        checks++; if (validTri_R10H !== 1'b1) begin failures++; $display("FAIL first_push_valid got=%b want=1", validTri_R10H); end
        checks++; if (tri_R10S !== tri_of(0)) begin failures++; $display("FAIL first_push_tri got=%h want=%h", tri_R10S, tri_of(0)); end
        checks++; if (tri_R10S[0][0] !== 24'h000400 || tri_R10S[0][1] !== 24'h000800 || tri_R10S[0][2] !== 24'h0) begin failures++; $display("FAIL first_push_v0 got=%h want=000400000800000000", tri_R10S[0]); end
        checks++; if (color_R10U !== col_of(0)) begin failures++; $display("FAIL first_push_color got=%h want=%h", color_R10U, col_of(0)); end
        checks++; if (count_U !== 3'd1) begin failures++; $display("FAIL first_push_count got=%0d want=1", count_U); end
        halt_RnnnnL = 1'b1;
        step();
        halt_RnnnnL = 1'b0;
        checks++; if (validTri_R10H !== 1'b0 || count_U !== 3'd0) begin failures++; $display("FAIL first_pop got valid=%b count=%0d want valid=0 count=0", validTri_R10H, count_U); end
    endtask

    task automatic test_fill_backpressure();
        halt_RnnnnL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(i);
            step();
        end
        checks++; if (count_U !== 3'd4 || in_ready_H !== 1'b0) begin failures++; $display("FAIL fill_full got count=%0d ready=%b want count=4 ready=0", count_U, in_ready_H); end
        offer(4);
        step();
        checks++; if (count_U !== 3'd4) begin failures++; $display("FAIL fill_held_count got=%0d want=4", count_U); end
        checks++; if (tri_R10S !== tri_of(0)) begin failures++; $display("FAIL fill_head_t0 got=%h want=%h", tri_R10S, tri_of(0)); end
        halt_RnnnnL = 1'b1;
        step();
        halt_RnnnnL = 1'b0;
        checks++; if (count_U !== 3'd3 || in_ready_H !== 1'b1) begin failures++; $display("FAIL full_pop_no_push got count=%0d ready=%b want count=3 ready=1", count_U, in_ready_H); end
        checks++; if (tri_R10S !== tri_of(1)) begin failures++; $display("FAIL full_pop_head got=%h want=%h", tri_R10S, tri_of(1)); end
        step();
        in_valid_H = 1'b0;
        checks++; if (count_U !== 3'd4 || in_ready_H !== 1'b0) begin failures++; $display("FAIL t4_taken got count=%0d ready=%b want count=4 ready=0", count_U, in_ready_H); end
        halt_RnnnnL = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (validTri_R10H !== 1'b1 || tri_R10S !== tri_of(k) || color_R10U !== col_of(k)) begin failures++; $display("FAIL drain_order_%0d got valid=%b tri=%h col=%h want tri=%h col=%h", k, validTri_R10H, tri_R10S, color_R10U, tri_of(k), col_of(k)); end
            step();
        end
        halt_RnnnnL = 1'b0;
        checks++; if (validTri_R10H !== 1'b0 || count_U !== 3'd0) begin failures++; $display("FAIL drain_empty got valid=%b count=%0d want valid=0 count=0", validTri_R10H, count_U); end
    endtask

    task automatic test_streaming();
        halt_RnnnnL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(10 + i);
            step();
            checks++; if (validTri_R10H !== 1'b1 || count_U !== 3'd1 || tri_R10S !== tri_of(10 + i) || color_R10U !== col_of(10 + i)) begin failures++; $display("FAIL stream_%0d got valid=%b count=%0d tri=%h want count=1 tri=%h", i, validTri_R10H, count_U, tri_R10S, tri_of(10 + i)); end
        end
        in_valid_H = 1'b0;
        step();
        halt_RnnnnL = 1'b0;
        checks++; if (validTri_R10H !== 1'b0 || count_U !== 3'd0) begin failures++; $display("FAIL stream_end got valid=%b count=%0d want valid=0 count=0", validTri_R10H, count_U); end
    endtask

    task automatic test_push_pop();
        halt_RnnnnL = 1'b0;
        offer(20); step();
        offer(21); step();
        offer(22);
        halt_RnnnnL = 1'b1;
        step();
        in_valid_H = 1'b0;
        checks++; if (count_U !== 3'd2 || tri_R10S !== tri_of(21)) begin failures++; $display("FAIL pushpop got count=%0d tri=%h want count=2 tri=%h", count_U, tri_R10S, tri_of(21)); end
        step();
        checks++; if (count_U !== 3'd1 || tri_R10S !== tri_of(22)) begin failures++; $display("FAIL pushpop_tail got count=%0d tri=%h want count=1 tri=%h", count_U, tri_R10S, tri_of(22)); end
        step();
        halt_RnnnnL = 1'b0;
        checks++; if (count_U !== 3'd0) begin failures++; $display("FAIL pushpop_empty got count=%0d want=0", count_U); end
    endtask

    task automatic test_flush();
        halt_RnnnnL = 1'b0;
        offer(30); step();
        offer(31); step();
        offer(32); step();
        checks++; if (count_U !== 3'd3) begin failures++; $display("FAIL preflush_count got=%0d want=3", count_U); end
        offer(33);
        halt_RnnnnL = 1'b1;
        flush_H = 1'b1;
        step();
        flush_H = 1'b0;
        in_valid_H = 1'b0;
        halt_RnnnnL = 1'b0;
        checks++; if (count_U !== 3'd0 || validTri_R10H !== 1'b0 || in_ready_H !== 1'b1) begin failures++; $display("FAIL flush got count=%0d valid=%b ready=%b want count=0 valid=0 ready=1", count_U, validTri_R10H, in_ready_H); end
        step();
        checks++; if (count_U !== 3'd0 || validTri_R10H !== 1'b0) begin failures++; $display("FAIL flush_discard got count=%0d valid=%b want count=0 valid=0", count_U, validTri_R10H); end
        offer(34); step();
        in_valid_H = 1'b0;
        checks++; if (count_U !== 3'd1 || tri_R10S !== tri_of(34)) begin failures++; $display("FAIL postflush_push got count=%0d tri=%h want count=1 tri=%h", count_U, tri_R10S, tri_of(34)); end
        halt_RnnnnL = 1'b1; step(); halt_RnnnnL = 1'b0;
    endtask

    task automatic test_async_reset();
        halt_RnnnnL = 1'b0;
        offer(40); step();
        offer(41); step();
        offer(42); step();
        in_valid_H = 1'b0;
        checks++; if (count_U !== 3'd3 || validTri_R10H !== 1'b1) begin failures++; $display("FAIL prereset_state got count=%0d valid=%b want count=3 valid=1", count_U, validTri_R10H); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (validTri_R10H !== 1'b0 || count_U !== 3'd0 || in_ready_H !== 1'b1) begin failures++; $display("FAIL async_reset got valid=%b count=%0d ready=%b want valid=0 count=0 ready=1", validTri_R10H, count_U, in_ready_H); end
        checks++; if (tri_R10S !== '0 || color_R10U !== '0) begin failures++; $display("FAIL async_reset_data got tri=%h col=%h want 0", tri_R10S, color_R10U); end
        step();
        rst = 1'b1;
        step();
        checks++; if (validTri_R10H !== 1'b0 || count_U !== 3'd0) begin failures++; $display("FAIL post_reset got valid=%b count=%0d want valid=0 count=0", validTri_R10H, count_U); end
    endtask

    initial begin
        test_reset();
        test_fill_backpressure();
        test_streaming();
        test_push_pop();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
